alt_stats_p: RTL and testbench

- Parametrised next-generation ambient-light threshold statistics engine on the pixel clock.
- Compares DVI and CCD pixel streams per channel.
- Accumulates per-frame absolute channel differences (ambient shift), the squared frame difference FD2 = dR²+dG²+dB², and FD2².
- At end of frame, a shared sequential divider produces ambient shift, mean FD2 and variance of FD2. Division is by the actual valid pixel count, not a constant.
- Each live pixel is also flagged as an outlier against the previous frame's statistics.

---
 rtl/alt_stats_p.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_alt_stats_p.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alt_stats_p.sv
// ---------------------------------------------------------------------------
// alt_stats_p : ambient-light threshold statistics engine (pixel clock)
//
// Compares DVI and CCD pixel streams per channel.  Every valid pixel adds
// |dR|,|dG|,|dB|, FD2 = dR^2+dG^2+dB^2 and FD2^2 to per-frame accumulators.
// At end of frame a shared restoring divider (one quotient bit per cycle)
// divides the frame totals by the real pixel count.  Each live pixel is also
// flagged as an outlier against the statistics of the last completed frame.
//
// Ports
//   clk_pixl, reset            pixel clock, async active-low reset
//   valid_i, syncX_i, syncY_i  pixel qualifier and coordinates
//   DVI_*_i, CCD_*_i           display / camera pixel channels
//   ovr_clr_i                  clears the sticky overrun flag
//   amb_shift_*_o              mean |delta| per channel, scaled to SHIFT_W
//   mean_o, var_o              mean and variance of FD2, last frame
//   stats_valid_o              one-cycle pulse when the stats outputs update
//   busy_o                     divider running
//   overrun_o                  sticky: end of frame arrived while busy
//   pix_valid_o, outlier_o     per-pixel outlier flag and its qualifier
//
// Divider FSM
//   state   | meaning
//   ST_IDLE | waiting for an end-of-frame snapshot
//   ST_DIV  | running the five divides, one quotient bit per cycle
//   ST_FIN  | quotients ready; outputs update and stats_valid_o pulses
// ---------------------------------------------------------------------------
module alt_stats_p #(
   parameter int H_ACT    = 640,
   parameter int V_ACT    = 480,
   parameter int XY_W     = 10,
   parameter int RW       = 5,
   parameter int GW       = 6,
   parameter int BW       = 5,
   parameter int DW       = 6,
   parameter int SHIFT_W  = 8,
   parameter int K2_SHIFT = 2,
   parameter int DIV_W    = 64,
   localparam int FDW     = 2*DW + 2
) (
   input  logic                 clk_pixl,
   input  logic                 reset,
   input  logic                 valid_i,
   input  logic [XY_W-1:0]      syncX_i,
   input  logic [XY_W-1:0]      syncY_i,
   input  logic [RW-1:0]        DVI_R_i,
   input  logic [GW-1:0]        DVI_G_i,
   input  logic [BW-1:0]        DVI_B_i,
   input  logic [RW-1:0]        CCD_R_i,
   input  logic [GW-1:0]        CCD_G_i,
   input  logic [BW-1:0]        CCD_B_i,
   input  logic                 ovr_clr_i,
   output logic [SHIFT_W-1:0]   amb_shift_r_o,
   output logic [SHIFT_W-1:0]   amb_shift_g_o,
   output logic [SHIFT_W-1:0]   amb_shift_b_o,
   output logic [FDW-1:0]       mean_o,
   output logic [2*FDW-1:0]     var_o,
   output logic                 stats_valid_o,
   output logic                 busy_o,
   output logic                 overrun_o,
   output logic                 pix_valid_o,
   output logic                 outlier_o
);

   localparam int MAX_PIX = H_ACT * V_ACT;
   localparam int CNT_W   = $clog2(MAX_PIX + 1);
   localparam int BC_W    = $clog2(DIV_W);
   localparam int CMP_W   = 2*FDW + K2_SHIFT;

   typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_FIN} state_t;

   state_t state, state_nx;

   // pipeline registers
   logic            s1_v, s1_eof, s2_v, s2_eof, s3_v, s3_eof, s4_v, s4_eof;
   logic [DW-1:0]   s1_dvi_r, s1_dvi_g, s1_dvi_b, s1_ccd_r, s1_ccd_g, s1_ccd_b;
   logic [DW-1:0]   s2_d_r, s2_d_g, s2_d_b, s3_d_r, s3_d_g, s3_d_b;
   logic [DW-1:0]   s4_d_r, s4_d_g, s4_d_b;
   logic [2*DW-1:0] s3_sq_r, s3_sq_g, s3_sq_b;
   logic [FDW-1:0]  s4_fd2;

   // accumulators
   logic [DIV_W-1:0] sum_r, sum_g, sum_b, sum_f, sum_q;
   logic [DIV_W-1:0] sum_r_nx, sum_g_nx, sum_b_nx, sum_f_nx, sum_q_nx;
   logic [CNT_W-1:0] cnt, cnt_inc;
   logic [2*FDW-1:0] fd2_sq;
   logic             eof_acc, start;

   // divider
   logic [DIV_W-1:0] dvd, q_nx, q_sq;
   logic [DIV_W-1:0] pend [4];
   logic [CNT_W-1:0] rem, rem_nx, n_div;
   logic [CNT_W:0]   trial;
   logic             ge;
   logic [BC_W-1:0]  bit_cnt;
   logic [2:0]       op;
   logic [SHIFT_W-1:0] q_r, q_g, q_b;
   logic [FDW-1:0]   q_mean;
   logic [DIV_W-1:0] mean_sq, var_full;

   // outlier compare
   logic [FDW-1:0]   dev;
   logic [2*FDW-1:0] dev_sq;
   logic [CMP_W-1:0] thr;

   assign busy_o = (state != ST_IDLE);

   // ---------------- pixel pipeline ----------------
   always_ff @(posedge clk_pixl or negedge reset) begin
      if (!reset) begin
         s1_v <= 1'b0; s1_eof <= 1'b0; s2_v <= 1'b0; s2_eof <= 1'b0;
         s3_v <= 1'b0; s3_eof <= 1'b0; s4_v <= 1'b0; s4_eof <= 1'b0;
         s1_dvi_r <= '0; s1_dvi_g <= '0; s1_dvi_b <= '0;
         s1_ccd_r <= '0; s1_ccd_g <= '0; s1_ccd_b <= '0;
         s2_d_r <= '0; s2_d_g <= '0; s2_d_b <= '0;
         s3_d_r <= '0; s3_d_g <= '0; s3_d_b <= '0;
         s4_d_r <= '0; s4_d_g <= '0; s4_d_b <= '0;
         s3_sq_r <= '0; s3_sq_g <= '0; s3_sq_b <= '0;
         s4_fd2 <= '0;
      end else begin
         s1_v     <= valid_i;
         s1_eof   <= valid_i && (syncX_i == XY_W'(H_ACT-1)) && (syncY_i == XY_W'(V_ACT-1));
         s1_dvi_r <= DW'(DVI_R_i) << (DW-RW);
         s1_dvi_g <= DW'(DVI_G_i) << (DW-GW);
         s1_dvi_b <= DW'(DVI_B_i) << (DW-BW);
         s1_ccd_r <= DW'(CCD_R_i) << (DW-RW);
         s1_ccd_g <= DW'(CCD_G_i) << (DW-GW);
         s1_ccd_b <= DW'(CCD_B_i) << (DW-BW);

         s2_v   <= s1_v;
         s2_eof <= s1_eof;
         s2_d_r <= (s1_dvi_r >= s1_ccd_r) ? s1_dvi_r - s1_ccd_r : s1_ccd_r - s1_dvi_r;
         s2_d_g <= (s1_dvi_g >= s1_ccd_g) ? s1_dvi_g - s1_ccd_g : s1_ccd_g - s1_dvi_g;
         s2_d_b <= (s1_dvi_b >= s1_ccd_b) ? s1_dvi_b - s1_ccd_b : s1_ccd_b - s1_dvi_b;

         s3_v    <= s2_v;
         s3_eof  <= s2_eof;
         s3_d_r  <= s2_d_r;
         s3_d_g  <= s2_d_g;
         s3_d_b  <= s2_d_b;
         s3_sq_r <= (2*DW)'(s2_d_r) * (2*DW)'(s2_d_r);
         s3_sq_g <= (2*DW)'(s2_d_g) * (2*DW)'(s2_d_g);
         s3_sq_b <= (2*DW)'(s2_d_b) * (2*DW)'(s2_d_b);

         s4_v   <= s3_v;
         s4_eof <= s3_eof;
         s4_d_r <= s3_d_r;
         s4_d_g <= s3_d_g;
         s4_d_b <= s3_d_b;
         s4_fd2 <= FDW'(s3_sq_r) + FDW'(s3_sq_g) + FDW'(s3_sq_b);
      end
   end

   // ---------------- accumulation ----------------
   always_comb begin
      fd2_sq   = (2*FDW)'(s4_fd2) * (2*FDW)'(s4_fd2);
      cnt_inc  = cnt + CNT_W'(1);
      sum_r_nx = sum_r + DIV_W'(s4_d_r);
      sum_g_nx = sum_g + DIV_W'(s4_d_g);
      sum_b_nx = sum_b + DIV_W'(s4_d_b);
      sum_f_nx = sum_f + DIV_W'(s4_fd2);
      sum_q_nx = sum_q + DIV_W'(fd2_sq);
      // a frame that reaches MAX_PIX without the last-pixel coordinate is
      // closed anyway so a lost sync cannot overflow the count
      eof_acc  = s4_v && (s4_eof || (cnt == CNT_W'(MAX_PIX-1)));
      start    = eof_acc && (state == ST_IDLE);
   end

   always_ff @(posedge clk_pixl or negedge reset) begin
      if (!reset) begin
         sum_r <= '0; sum_g <= '0; sum_b <= '0; sum_f <= '0; sum_q <= '0;
         cnt   <= '0;
      end else if (s4_v) begin
         if (eof_acc) begin
            sum_r <= '0; sum_g <= '0; sum_b <= '0; sum_f <= '0; sum_q <= '0;
            cnt   <= '0;
         end else begin
            sum_r <= sum_r_nx; sum_g <= sum_g_nx; sum_b <= sum_b_nx;
            sum_f <= sum_f_nx; sum_q <= sum_q_nx;
            cnt   <= cnt_inc;
         end
      end
   end

   // ---------------- divider FSM ----------------
   always_ff @(posedge clk_pixl or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      trial    = {rem, dvd[DIV_W-1]};
      ge       = (trial >= {1'b0, n_div});
      rem_nx   = ge ? CNT_W'(trial - {1'b0, n_div}) : CNT_W'(trial);
      q_nx     = {dvd[DIV_W-2:0], ge};
      mean_sq  = DIV_W'((2*FDW)'(q_mean) * (2*FDW)'(q_mean));
      var_full = (q_sq >= mean_sq) ? q_sq - mean_sq : '0;
      case (state)
         ST_IDLE: if (start) state_nx = ST_DIV;
         ST_DIV:  if ((bit_cnt == '0) && (op == 3'd4)) state_nx = ST_FIN;
         ST_FIN:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // The dividend register doubles as the quotient register: quotient bits
   // shift in from the bottom as dividend bits leave from the top.
   always_ff @(posedge clk_pixl or negedge reset) begin
      if (!reset) begin
         dvd <= '0; rem <= '0; n_div <= '0; bit_cnt <= '0; op <= '0;
         for (int i = 0; i < 4; i++) pend[i] <= '0;
         q_r <= '0; q_g <= '0; q_b <= '0; q_mean <= '0; q_sq <= '0;
      end else if (start) begin
         dvd     <= sum_r_nx << (SHIFT_W-DW);
         pend[0] <= sum_g_nx << (SHIFT_W-DW);
         pend[1] <= sum_b_nx << (SHIFT_W-DW);
         pend[2] <= sum_f_nx;
         pend[3] <= sum_q_nx;
         n_div   <= cnt_inc;
         rem     <= '0;
         bit_cnt <= BC_W'(DIV_W-1);
         op      <= '0;
      end else if (state == ST_DIV) begin
         if (bit_cnt == '0) begin
            case (op)
               3'd0:    q_r    <= SHIFT_W'(q_nx);
               3'd1:    q_g    <= SHIFT_W'(q_nx);
               3'd2:    q_b    <= SHIFT_W'(q_nx);
               3'd3:    q_mean <= FDW'(q_nx);
               default: q_sq   <= q_nx;
            endcase
            if (op != 3'd4) begin
               dvd     <= pend[0];
               pend[0] <= pend[1];
               pend[1] <= pend[2];
               pend[2] <= pend[3];
               pend[3] <= '0;
               rem     <= '0;
               bit_cnt <= BC_W'(DIV_W-1);
               op      <= op + 3'd1;
            end
         end else begin
            dvd     <= q_nx;
            rem     <= rem_nx;
            bit_cnt <= bit_cnt - BC_W'(1);
         end
      end
   end

   // ---------------- outputs ----------------
   always_ff @(posedge clk_pixl or negedge reset) begin
      if (!reset) begin
         amb_shift_r_o <= '0; amb_shift_g_o <= '0; amb_shift_b_o <= '0;
         mean_o <= '0; var_o <= '0; stats_valid_o <= 1'b0;
      end else if (state == ST_FIN) begin
         amb_shift_r_o <= q_r;
         amb_shift_g_o <= q_g;
         amb_shift_b_o <= q_b;
         mean_o        <= q_mean;
         var_o         <= (2*FDW)'(var_full);
         stats_valid_o <= 1'b1;
      end else begin
         stats_valid_o <= 1'b0;
      end
   end

   always_ff @(posedge clk_pixl or negedge reset) begin
      if (!reset)                      overrun_o <= 1'b0;
      else if (eof_acc && busy_o)      overrun_o <= 1'b1;
      else if (ovr_clr_i)              overrun_o <= 1'b0;
   end

   always_comb begin
      dev    = (s4_fd2 >= mean_o) ? s4_fd2 - mean_o : mean_o - s4_fd2;
      dev_sq = (2*FDW)'(dev) * (2*FDW)'(dev);
      thr    = CMP_W'(var_o) << K2_SHIFT;
   end

   always_ff @(posedge clk_pixl or negedge reset) begin
      if (!reset) begin
         pix_valid_o <= 1'b0;
         outlier_o   <= 1'b0;
      end else begin
         pix_valid_o <= s4_v;
         outlier_o   <= s4_v && (CMP_W'(dev_sq) > thr);
      end
   end

endmodule

// File: tb/tb_alt_stats_p.sv
module tb_alt_stats_p;
   localparam int H = 4, V = 2, XY_W = 10, RW = 5, GW = 6, BW = 5, DW = 6;
   localparam int SHIFT_W = 8, K2 = 2, DIV_W = 64, FDW = 2*DW + 2;
   localparam int LAT = 5*DIV_W + 1;

   logic clk_pixl = 1'b0, reset = 1'b0, valid_i = 1'b0, ovr_clr_i = 1'b0;
   logic [XY_W-1:0] syncX_i = '0, syncY_i = '0;
   logic [RW-1:0] DVI_R_i = '0, CCD_R_i = '0;
   logic [GW-1:0] DVI_G_i = '0, CCD_G_i = '0;
   logic [BW-1:0] DVI_B_i = '0, CCD_B_i = '0;
   logic [SHIFT_W-1:0] amb_shift_r_o, amb_shift_g_o, amb_shift_b_o;
   logic [FDW-1:0] mean_o;
   logic [2*FDW-1:0] var_o;
   logic stats_valid_o, busy_o, overrun_o, pix_valid_o, outlier_o;

   alt_stats_p #(.H_ACT(H), .V_ACT(V), .XY_W(XY_W), .RW(RW), .GW(GW), .BW(BW),
                 .DW(DW), .SHIFT_W(SHIFT_W), .K2_SHIFT(K2), .DIV_W(DIV_W)) dut (
      .clk_pixl(clk_pixl), .reset(reset), .valid_i(valid_i),
      .syncX_i(syncX_i), .syncY_i(syncY_i),
      .DVI_R_i(DVI_R_i), .DVI_G_i(DVI_G_i), .DVI_B_i(DVI_B_i),
      .CCD_R_i(CCD_R_i), .CCD_G_i(CCD_G_i), .CCD_B_i(CCD_B_i),
      .ovr_clr_i(ovr_clr_i),
      .amb_shift_r_o(amb_shift_r_o), .amb_shift_g_o(amb_shift_g_o),
      .amb_shift_b_o(amb_shift_b_o), .mean_o(mean_o), .var_o(var_o),
      .stats_valid_o(stats_valid_o), .busy_o(busy_o), .overrun_o(overrun_o),
      .pix_valid_o(pix_valid_o), .outlier_o(outlier_o));

   always #5 clk_pixl = ~clk_pixl;

   int unsigned cyc = 0;
   always @(posedge clk_pixl) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] r, g, b, mean, vr;
      int unsigned at;
   } stat_t;

   stat_t sb[$];
   longint unsigned fdq[$];
   int n_assert = 0, n_fail = 0;
   bit mon_en = 1'b0;

   longint unsigned m_sr = 0, m_sg = 0, m_sb = 0, m_sf = 0, m_sq = 0;
   int m_n = 0;
   int unsigned last_e0 = 0;
   bit have_e0 = 1'b0, exp_ovr = 1'b0;
   longint unsigned mdl_mean = 0, mdl_var = 0;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned absd(longint unsigned a, longint unsigned b);
      return (a >= b) ? a - b : b - a;
   endfunction

   // drive one valid pixel and update the reference model
   task automatic send(int dr, int dg, int db, int cr, int cg, int cb, int x, int y);
      longint unsigned ar, ag, ab, fd;
      stat_t s;
      longint unsigned e2, m;
      int unsigned e0;
      @(negedge clk_pixl);
      valid_i = 1'b1;
      DVI_R_i = RW'(dr); DVI_G_i = GW'(dg); DVI_B_i = BW'(db);
      CCD_R_i = RW'(cr); CCD_G_i = GW'(cg); CCD_B_i = BW'(cb);
      syncX_i = XY_W'(x); syncY_i = XY_W'(y);
      ar = absd(longint'(dr) << (DW-RW), longint'(cr) << (DW-RW));
      ag = absd(longint'(dg) << (DW-GW), longint'(cg) << (DW-GW));
      ab = absd(longint'(db) << (DW-BW), longint'(cb) << (DW-BW));
      fd = ar*ar + ag*ag + ab*ab;
      fdq.push_back(fd);
      m_sr += ar; m_sg += ag; m_sb += ab; m_sf += fd; m_sq += fd*fd; m_n++;
      if ((x == H-1 && y == V-1) || m_n == H*V) begin
         e0 = cyc + 1 + 4;
         if (have_e0 && e0 <= last_e0 + LAT) begin
            exp_ovr = 1'b1;
         end else begin
            s.r    = ((m_sr << (SHIFT_W-DW)) / longint'(m_n)) & 64'hFF;
            s.g    = ((m_sg << (SHIFT_W-DW)) / longint'(m_n)) & 64'hFF;
            s.b    = ((m_sb << (SHIFT_W-DW)) / longint'(m_n)) & 64'hFF;
            m      = (m_sf / longint'(m_n)) & ((64'd1 << FDW) - 1);
            e2     = m_sq / longint'(m_n);
            s.mean = m;
            s.vr   = ((e2 >= m*m) ? e2 - m*m : 0) & ((64'd1 << (2*FDW)) - 1);
            s.at   = e0 + LAT;
            sb.push_back(s);
            last_e0 = e0;
            have_e0 = 1'b1;
         end
         m_sr = 0; m_sg = 0; m_sb = 0; m_sf = 0; m_sq = 0; m_n = 0;
      end
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_pixl);
         valid_i = 1'b0;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 2000 && (sb.size() != 0 || busy_o); i++) @(negedge clk_pixl);
      check("drain_pending", sb.size(), 0);
      idle(8);
   endtask

   // monitor: pixel results first (they used the pre-update stats), then stats
   always @(negedge clk_pixl) begin
      if (mon_en) begin
         if (pix_valid_o) begin
            if (fdq.size() == 0) check("pix_unexpected", pix_valid_o, 0);
            else begin
               longint unsigned f, d;
               f = fdq.pop_front();
               d = absd(f, mdl_mean);
               check("outlier", outlier_o, (d*d > (mdl_var << K2)) ? 1 : 0);
            end
         end else begin
            check("outlier_idle", outlier_o, 0);
         end
         if (stats_valid_o) begin
            if (sb.size() == 0) check("stats_unexpected", stats_valid_o, 0);
            else begin
               stat_t s;
               s = sb.pop_front();
               check("amb_r", amb_shift_r_o, s.r);
               check("amb_g", amb_shift_g_o, s.g);
               check("amb_b", amb_shift_b_o, s.b);
               check("mean", mean_o, s.mean);
               check("var", var_o, s.vr);
               check("stats_cycle", cyc, s.at);
               check("busy_at_stats", busy_o, 0);
               mdl_mean = s.mean;
               mdl_var  = s.vr;
            end
         end
      end
   end

   initial begin
      // 1. reset
      repeat (4) @(negedge clk_pixl);
      check("rst_stats_valid", stats_valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_mean", mean_o, 0);
      reset = 1'b1;
      mon_en = 1'b1;
      idle(3);
      check("post_rst_amb_r", amb_shift_r_o, 0);
      check("post_rst_var", var_o, 0);
      check("post_rst_overrun", overrun_o, 0);
      check("post_rst_pix_valid", pix_valid_o, 0);

      // 2. uniform frame, dR=12
      for (int i = 0; i < 8; i++) send(10, 7, 3, 4, 7, 3, i % 4, i / 4);
      idle(6);
      check("busy_running", busy_o, 1);
      drain();
      check("t2_amb_r", amb_shift_r_o, 48);
      check("t2_amb_g", amb_shift_g_o, 0);
      check("t2_mean", mean_o, 144);
      check("t2_var", var_o, 0);

      // 3. alternating dR=12 / 0
      for (int i = 0; i < 8; i++)
         if (i % 2 == 0) send(10, 7, 3, 4, 7, 3, i % 4, i / 4);
         else            send(4, 7, 3, 4, 7, 3, i % 4, i / 4);
      idle(2);
      drain();
      check("t3_amb_r", amb_shift_r_o, 24);
      check("t3_mean", mean_o, 72);
      check("t3_var", var_o, 5184);

      // 4. same with bubbles
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) send(10, 7, 3, 4, 7, 3, i % 4, i / 4);
         else            send(4, 7, 3, 4, 7, 3, i % 4, i / 4);
         idle(1 + i % 3);
      end
      drain();
      check("t4_mean", mean_o, 72);
      check("t4_var", var_o, 5184);

      // 5. outliers against mean 72 / var 5184
      send(10, 7, 3, 4, 7, 3, 0, 0);
      send(31, 7, 3, 0, 7, 3, 1, 0);
      for (int i = 2; i < 8; i++) send(9, 5, 5, 9, 5, 5, i % 4, i / 4);
      idle(2);
      drain();

      // random frame
      for (int i = 0; i < 8; i++)
         send($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 31),
              i % 4, i / 4);
      idle(2);
      drain();

      // 6. overrun: two EOFs close together
      for (int i = 0; i < 8; i++) send(20, 30, 10, 2, 40, 10, i % 4, i / 4);
      for (int i = 0; i < 8; i++) send(5, 5, 5, 25, 5, 5, i % 4, i / 4);
      idle(8);
      check("overrun_set", overrun_o, exp_ovr);
      @(negedge clk_pixl) ovr_clr_i = 1'b1;
      @(negedge clk_pixl) ovr_clr_i = 1'b0;
      check("overrun_clr", overrun_o, 0);
      drain();

      // forced EOF: no last-pixel coordinate
      for (int i = 0; i < 8; i++) send(15, 20, 8, 3, 10, 8, 0, 0);
      idle(2);
      drain();
      check("fdq_empty", fdq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
